uart_baud_ctrl: RTL and testbench

- Generates the bit-period sampling strobes for the UART TX and RX datapaths.
- Consumes the per-channel strobe-enable requests and returns single-cycle strobes; `o_rx_strb` drives the RX path's `i_rx_strb`.
- Owns the baud divisor and applies divisor reloads only when no frame is in flight, so reconfiguration never corrupts an active character.
- Sits between the AXI4-Lite register file and the `uart_tx`/`uart_rx` datapaths.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_strb_chan.sv | 105 ++++++++++
 rtl/uart_baud_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_baud_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-strobe generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        RUN  = 2'd2
    } strb_chan_state_t;

    typedef enum logic {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

    localparam int UART_MIN_DIVISOR = 2;

endpackage

// File: rtl/uart_strb_chan.sv
// One strobe channel: down-counter, optional fractional accumulator (UART_BAUD_FRAC_EN).
// Latency: first strobe D (or max(1,D>>1) with HALF_FIRST) cycles after enable; strobe registered.
// Backpressure: none; dropping enable aborts the frame and suppresses a same-cycle strobe.
module uart_strb_chan
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_BITS  = 4,
    parameter bit HALF_FIRST = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [FRAC_BITS-1:0] frac,
    output logic                 strb,
    output logic                 idle
);

    // One spare bit so D + carry never wraps at the maximum divisor.
    localparam int CW = DIV_WIDTH + 1;

    strb_chan_state_t state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    full_period, plain_period, half_period;
    logic             strb_d;
    logic             expire;

    assign expire       = (cnt_q == CW'(1));
    assign plain_period = {1'b0, div};
    assign half_period  = ((div >> 1) == '0) ? CW'(1) : CW'(div >> 1);

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] acc_q, acc_d, acc_sum;
    logic                 carry;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac};
    assign full_period      = plain_period + CW'(carry);

    always_comb begin
        acc_d = acc_q;
        if (!en || state_q == IDLE) begin
            acc_d = '0;
        end else if (state_q == RUN && expire) begin
            acc_d = acc_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^frac;
    assign full_period = plain_period;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            strb    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            strb    <= strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = HALF_FIRST ? HALF : RUN;
                HALF:    if (expire) state_d = RUN;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        strb_d = 1'b0;
        if (!en) begin
            cnt_d = '0;
        end else if (state_q == IDLE) begin
            cnt_d = HALF_FIRST ? half_period : plain_period;
        end else if (expire) begin
            strb_d = 1'b1;
            // The half-period leg hands over a plain D; the fraction only accrues in RUN.
            cnt_d  = (state_q == RUN) ? full_period : plain_period;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign idle = (state_q == IDLE);

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud divisor owner and TX/RX strobe generator; fractional divisor under UART_BAUD_FRAC_EN.
// Latency: idle-time divisor load effective next cycle; strobes one cycle wide, registered.
// Backpressure: loads arriving mid-frame wait (o_cfg_busy) until both channels are idle.
module uart_baud_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH     = 16,
    parameter int FRAC_BITS     = 4,
    parameter int RESET_DIVISOR = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] i_divisor,
    input  logic [FRAC_BITS-1:0] i_divisor_frac,
    input  logic                 i_cfg_load,
    output logic                 o_cfg_busy,
    output logic                 o_cfg_error,
    input  logic                 i_tx_strb_en,
    output logic                 o_tx_strb,
    input  logic                 i_rx_strb_en,
    output logic                 o_rx_strb
);

    cfg_state_t           cfg_q, cfg_d;
    logic [DIV_WIDTH-1:0] div_q, pend_div_q;
    logic [FRAC_BITS-1:0] frac_q;
    logic                 cfg_error_q;
    logic                 tx_idle, rx_idle;
    logic                 load_ok, load_bad, chans_quiet, apply;

    assign load_ok     = i_cfg_load && (i_divisor >= DIV_WIDTH'(UART_MIN_DIVISOR));
    assign load_bad    = i_cfg_load && !load_ok;
    assign chans_quiet = tx_idle && rx_idle && !i_tx_strb_en && !i_rx_strb_en;
    // A fresh valid load takes priority over the stored one (last wins).
    assign apply       = chans_quiet && (load_ok || cfg_q == CFG_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= CFG_IDLE;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    always_comb begin
        cfg_d = cfg_q;
        if (apply) begin
            cfg_d = CFG_IDLE;
        end else if (load_ok) begin
            cfg_d = CFG_PENDING;
        end
    end

    always_comb begin
        o_cfg_busy = (cfg_q == CFG_PENDING);
    end

    assign o_cfg_error = cfg_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= DIV_WIDTH'(RESET_DIVISOR);
            pend_div_q  <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            if (load_bad) begin
                cfg_error_q <= 1'b1;
            end else if (load_ok) begin
                cfg_error_q <= 1'b0;
            end
            if (load_ok) begin
                pend_div_q <= i_divisor;
            end
            if (apply) begin
                div_q <= load_ok ? i_divisor : pend_div_q;
            end
        end
    end

`ifdef UART_BAUD_FRAC_EN
    logic [FRAC_BITS-1:0] pend_frac_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frac_q      <= '0;
            pend_frac_q <= '0;
        end else begin
            if (load_ok) begin
                pend_frac_q <= i_divisor_frac;
            end
            if (apply) begin
                frac_q <= load_ok ? i_divisor_frac : pend_frac_q;
            end
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^i_divisor_frac;
    assign frac_q      = '0;
`endif

    uart_strb_chan #(
        .DIV_WIDTH  (DIV_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .HALF_FIRST (1'b0)
    ) u_tx_chan (
        .clk  (clk),
        .rst  (rst),
        .en   (i_tx_strb_en),
        .div  (div_q),
        .frac (frac_q),
        .strb (o_tx_strb),
        .idle (tx_idle)
    );

    uart_strb_chan #(
        .DIV_WIDTH  (DIV_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .HALF_FIRST (1'b1)
    ) u_rx_chan (
        .clk  (clk),
        .rst  (rst),
        .en   (i_rx_strb_en),
        .div  (div_q),
        .frac (frac_q),
        .strb (o_rx_strb),
        .idle (rx_idle)
    );

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench: stimulus queues expected strobe edge numbers, a monitor pops and compares.
module tb_uart_baud_ctrl;

    localparam int DW = 16;
    localparam int FB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_divisor;
    logic [FB-1:0] i_divisor_frac;
    logic          i_cfg_load;
    logic          o_cfg_busy;
    logic          o_cfg_error;
    logic          i_tx_strb_en;
    logic          o_tx_strb;
    logic          i_rx_strb_en;
    logic          o_rx_strb;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int tx_q[$];
    int rx_q[$];

    always #5 clk = ~clk;

    // cyc holds the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    uart_baud_ctrl #(
        .DIV_WIDTH     (DW),
        .FRAC_BITS     (FB),
        .RESET_DIVISOR (868)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_divisor      (i_divisor),
        .i_divisor_frac (i_divisor_frac),
        .i_cfg_load     (i_cfg_load),
        .o_cfg_busy     (o_cfg_busy),
        .o_cfg_error    (o_cfg_error),
        .i_tx_strb_en   (i_tx_strb_en),
        .o_tx_strb      (o_tx_strb),
        .i_rx_strb_en   (i_rx_strb_en),
        .o_rx_strb      (o_rx_strb)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: each strobe must match the head of its channel's queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_strb) begin
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_strb: unexpected strobe at edge %0d", cyc);
                end else begin
                    check("tx_strb_edge", cyc, tx_q.pop_front());
                end
            end
            if (o_rx_strb) begin
                if (rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rx_strb: unexpected strobe at edge %0d", cyc);
                end else begin
                    check("rx_strb_edge", cyc, rx_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Presents a load for one edge; returns one negedge later with the effect visible.
    task automatic cfg_load(input int d, input int f);
        i_divisor      = DW'(d);
        i_divisor_frac = FB'(f);
        i_cfg_load     = 1'b1;
        @(negedge clk);
        i_cfg_load     = 1'b0;
    endtask

    initial begin
        int k;
        int k2;

        rst            = 1'b1;
        i_divisor      = '0;
        i_divisor_frac = '0;
        i_cfg_load     = 1'b0;
        i_tx_strb_en   = 1'b0;
        i_rx_strb_en   = 1'b0;
        step(3);
        check("reset_tx_strb", int'(o_tx_strb), 0);
        check("reset_rx_strb", int'(o_rx_strb), 0);
        check("reset_busy", int'(o_cfg_busy), 0);
        check("reset_error", int'(o_cfg_error), 0);
        rst = 1'b0;
        step(1);

        // Reset divisor 868: RX half period 434, then 868 apart.
        i_rx_strb_en = 1'b1;
        k = cyc + 1;
        rx_q.push_back(k + 434);
        rx_q.push_back(k + 1302);
        rx_q.push_back(k + 2170);
        wait_until(k + 2172);
        i_rx_strb_en = 1'b0;
        step(2);

        // Idle load D=10 F=8, TX spacing 10,11,10,11 with fraction, 10 without.
        cfg_load(10, 8);
        check("load10_busy", int'(o_cfg_busy), 0);
        check("load10_error", int'(o_cfg_error), 0);
        i_tx_strb_en = 1'b1;
        k = cyc + 1;
        tx_q.push_back(k + 10);
        tx_q.push_back(k + 20);
`ifdef UART_BAUD_FRAC_EN
        tx_q.push_back(k + 31);
        tx_q.push_back(k + 41);
        tx_q.push_back(k + 52);
        wait_until(k + 53);
`else
        tx_q.push_back(k + 30);
        tx_q.push_back(k + 40);
        tx_q.push_back(k + 50);
        wait_until(k + 51);
`endif
        i_tx_strb_en = 1'b0;
        step(2);

        // D=1 is rejected and leaves D=10 in place; D=16 then clears the error.
        cfg_load(1, 0);
        check("load1_error", int'(o_cfg_error), 1);
        check("load1_busy", int'(o_cfg_busy), 0);
        i_tx_strb_en = 1'b1;
        k = cyc + 1;
        tx_q.push_back(k + 10);
        wait_until(k + 11);
        i_tx_strb_en = 1'b0;
        step(2);
        cfg_load(16, 0);
        check("load16_error", int'(o_cfg_error), 0);
        check("load16_busy", int'(o_cfg_busy), 0);
        i_tx_strb_en = 1'b1;
        k = cyc + 1;
        tx_q.push_back(k + 16);
        tx_q.push_back(k + 32);
        wait_until(k + 33);
        i_tx_strb_en = 1'b0;
        step(2);

        // Load D=20 while RX runs: stays pending, frame keeps D=16.
        i_rx_strb_en = 1'b1;
        k = cyc + 1;
        rx_q.push_back(k + 8);
        rx_q.push_back(k + 24);
        rx_q.push_back(k + 40);
        wait_until(k + 10);
        cfg_load(20, 0);
        check("pend20_busy", int'(o_cfg_busy), 1);
        wait_until(k + 40);
        i_rx_strb_en = 1'b0;
        step(2);
        check("pend20_busy_cleared", int'(o_cfg_busy), 0);
        i_rx_strb_en = 1'b1;
        k2 = cyc + 1;
        rx_q.push_back(k2 + 10);
        rx_q.push_back(k2 + 30);
        wait_until(k2 + 31);
        i_rx_strb_en = 1'b0;
        step(2);

        // TX enable low exactly on the expiry edge, back high one edge later.
        i_tx_strb_en = 1'b1;
        k = cyc + 1;
        wait_until(k + 19);
        i_tx_strb_en = 1'b0;
        step(1);
        i_tx_strb_en = 1'b1;
        tx_q.push_back(k + 41);
        wait_until(k + 42);
        i_tx_strb_en = 1'b0;
        step(2);

        // Same for RX: half period 10, restart gives a fresh half period.
        i_rx_strb_en = 1'b1;
        k = cyc + 1;
        wait_until(k + 9);
        i_rx_strb_en = 1'b0;
        step(1);
        i_rx_strb_en = 1'b1;
        rx_q.push_back(k + 21);
        rx_q.push_back(k + 41);
        wait_until(k + 42);
        i_rx_strb_en = 1'b0;
        step(2);

        // Two pending loads, last wins; an invalid one in between keeps D=50.
        i_tx_strb_en = 1'b1;
        k = cyc + 1;
        tx_q.push_back(k + 20);
        wait_until(k + 5);
        cfg_load(40, 0);
        check("pend40_busy", int'(o_cfg_busy), 1);
        cfg_load(50, 0);
        check("pend50_busy", int'(o_cfg_busy), 1);
        check("pend50_error", int'(o_cfg_error), 0);
        cfg_load(0, 0);
        check("pend0_error", int'(o_cfg_error), 1);
        check("pend0_busy", int'(o_cfg_busy), 1);
        wait_until(k + 21);
        i_tx_strb_en = 1'b0;
        step(3);
        check("pend50_busy_cleared", int'(o_cfg_busy), 0);
        i_tx_strb_en = 1'b1;
        k2 = cyc + 1;
        tx_q.push_back(k2 + 50);
        wait_until(k2 + 55);

        // Reset mid-frame restores the reset divisor and clears the error flag.
        rst          = 1'b1;
        i_tx_strb_en = 1'b0;
        step(2);
        rst = 1'b0;
        check("rst_mid_busy", int'(o_cfg_busy), 0);
        check("rst_mid_error", int'(o_cfg_error), 0);
        step(1);
        i_rx_strb_en = 1'b1;
        k = cyc + 1;
        rx_q.push_back(k + 434);
        wait_until(k + 436);
        i_rx_strb_en = 1'b0;
        step(3);

        check("tx_missing_strobes", tx_q.size(), 0);
        check("rx_missing_strobes", rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
